// File: rtl/vp_cache_req_sched_if.sv
// vp_cache_req_sched_if: requester/NOC/response bundle; slave = scheduler (req_*, resp_*, mst_ready in; req_ready, mst_*, outst_cnt, idle, err out), master = environment
interface vp_cache_req_sched_if #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 128
);
  localparam int SW = $clog2(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*WIDTH-1:0] req_info;
  logic [N_REQ-1:0] req_ready;
  logic mst_valid;
  logic [WIDTH-1:0] mst_info;
  logic [SW-1:0] mst_src;
  logic mst_ready;
  logic resp_fire;
  logic [SW-1:0] resp_src;
  logic [N_REQ*4-1:0] outst_cnt;
  logic idle;
  logic err_resp_underflow;
  modport slave (
    input req_valid, req_info, mst_ready, resp_fire, resp_src,
    output req_ready, mst_valid, mst_info, mst_src, outst_cnt, idle, err_resp_underflow
  );
  modport master (
    output req_valid, req_info, mst_ready, resp_fire, resp_src,
    input req_ready, mst_valid, mst_info, mst_src, outst_cnt, idle, err_resp_underflow
  );
endinterface

// File: rtl/vp_cache_req_sched.sv
// vp_cache_req_sched: credit-aware weighted round-robin scheduler; ports clk, rst and bus (slave modport of vp_cache_req_sched_if)
module vp_cache_req_sched #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 128,
  parameter int MAX_OUTST = 4,
  parameter int WEIGHT = 2,
  parameter logic [N_REQ-1:0] RESP_MASK = 3'b101
) (
  input logic clk,
  input logic rst,
  vp_cache_req_sched_if.slave bus
);
  localparam int SW = $clog2(N_REQ);
  localparam logic [0:0] ARB = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0] state_q, state_d;
  logic [SW-1:0] rr_q, rr_d, owner_q, owner_d, src_q, src_d, g, arb_g, idx;
  logic [3:0] burst_q, burst_d;
  logic [3:0] cnt_q [N_REQ];
  logic [3:0] cnt_d [N_REQ];
  logic [WIDTH-1:0] info_q, info_d;
  logic mst_valid_q, mst_valid_d, err_q, err_d;
  logic [N_REQ-1:0] elig, inc, dec_ok;
  logic [N_REQ*4-1:0] cnt_flat;
  logic load_en, arb_found, grant_v, accept;
  function automatic logic [SW-1:0] nxt(input logic [SW-1:0] x);
    return x == SW'(N_REQ - 1) ? '0 : x + 1'b1;
  endfunction
  always_comb begin
    load_en = !mst_valid_q | bus.mst_ready;
    for (int i = 0; i < N_REQ; i++) elig[i] = bus.req_valid[i] & (!RESP_MASK[i] | (cnt_q[i] < 4'(MAX_OUTST)));
    arb_found = 1'b0;
    arb_g = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = SW'((int'(rr_q) + k) % N_REQ);
      if (!arb_found && elig[idx]) begin
        arb_found = 1'b1;
        arb_g = idx;
      end
    end
    grant_v = state_q == ARB ? arb_found : elig[owner_q];
    g = state_q == ARB ? arb_g : owner_q;
    accept = grant_v & load_en;
    state_d = state_q;
    rr_d = rr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    if (state_q == ARB) begin
      if (accept && WEIGHT > 1) begin
        state_d = BURST;
        owner_d = g;
        burst_d = 4'd1;
      end else if (accept) rr_d = nxt(g);
    end else if (!elig[owner_q] || (accept && burst_q + 4'd1 == 4'(WEIGHT))) begin
      state_d = ARB;
      rr_d = nxt(owner_q);
    end else if (accept) burst_d = burst_q + 4'd1;
    for (int i = 0; i < N_REQ; i++) begin
      inc[i] = accept & (g == SW'(i)) & RESP_MASK[i];
      dec_ok[i] = bus.resp_fire & (bus.resp_src == SW'(i)) & RESP_MASK[i] & (cnt_q[i] != 4'd0);
      cnt_d[i] = cnt_q[i] + {3'b0, inc[i]} - {3'b0, dec_ok[i]};
      cnt_flat[i*4 +: 4] = cnt_q[i];
    end
    err_d = err_q | (bus.resp_fire & ~|dec_ok);
    mst_valid_d = load_en ? accept : mst_valid_q;
    info_d = accept ? bus.req_info[int'(g)*WIDTH +: WIDTH] : info_q;
    src_d = accept ? g : src_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      rr_q <= '0;
      owner_q <= '0;
      burst_q <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      mst_valid_q <= 1'b0;
      info_q <= '0;
      src_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      mst_valid_q <= mst_valid_d;
      info_q <= info_d;
      src_q <= src_d;
      err_q <= err_d;
    end
  end
  assign bus.req_ready = accept ? N_REQ'(1) << g : '0;
  assign bus.mst_valid = mst_valid_q;
  assign bus.mst_info = info_q;
  assign bus.mst_src = src_q;
  assign bus.outst_cnt = cnt_flat;
  assign bus.idle = !mst_valid_q & ~|cnt_flat;
  assign bus.err_resp_underflow = err_q;
endmodule

// File: tb/tb_vp_cache_req_sched.sv
// tb_vp_cache_req_sched: directed self-checking bench for vp_cache_req_sched
module tb_vp_cache_req_sched;
  localparam int N = 3;
  localparam int W = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  vp_cache_req_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();
  vp_cache_req_sched #(.N_REQ(N), .WIDTH(W), .MAX_OUTST(4), .WEIGHT(2), .RESP_MASK(3'b101)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic logic [W-1:0] info(input int i);
    return {96'h0, 32'hC0DE_0000 + 32'(i)};
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic resp(input int src);
    bus.resp_fire = 1'b1;
    bus.resp_src = 2'(src);
    tick();
    bus.resp_fire = 1'b0;
  endtask
  int exp_rdy[7] = '{1, 1, 2, 2, 4, 4, 1};
  int exp_src[7] = '{0, 0, 0, 1, 1, 2, 2};
  initial begin
    bus.req_valid = '0;
    bus.req_info = {info(2), info(1), info(0)};
    bus.mst_ready = 1'b1;
    bus.resp_fire = 1'b0;
    bus.resp_src = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_valid", bus.mst_valid, 0);
    chk("rst_src", bus.mst_src, 0);
    chk("rst_info", bus.mst_info, 0);
    chk("rst_cnt", bus.outst_cnt, 0);
    chk("rst_idle", bus.idle, 1);
    chk("rst_err", bus.err_resp_underflow, 0);
    tick();
    bus.req_valid = 3'b111;
    for (int c = 0; c < 7; c++) begin
      settle();
      chk("wrr_ready", bus.req_ready, exp_rdy[c]);
      if (c == 0) chk("wrr_latency", bus.mst_valid, 0);
      else begin
        chk("wrr_valid", bus.mst_valid, 1);
        chk("wrr_src", bus.mst_src, exp_src[c]);
        chk("wrr_info", bus.mst_info, info(exp_src[c]));
      end
      tick();
    end
    bus.req_valid = '0;
    settle();
    chk("wrr_last_src", bus.mst_src, 0);
    chk("wrr_cnt", bus.outst_cnt, 12'h203);
    chk("wrr_ready_off", bus.req_ready, 0);
    tick();
    bus.resp_fire = 1'b1;
    bus.resp_src = 2'd0;
    settle();
    chk("wrr_drained_valid", bus.mst_valid, 0);
    chk("wrr_not_idle", bus.idle, 0);
    tick();
    bus.req_valid = 3'b001;
    settle();
    chk("same_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = '0;
    bus.resp_fire = 1'b0;
    settle();
    chk("same_cnt", bus.outst_cnt, 12'h202);
    tick();
    resp(0);
    resp(0);
    resp(2);
    resp(2);
    settle();
    chk("drain_cnt", bus.outst_cnt, 0);
    chk("drain_idle", bus.idle, 1);
    chk("drain_err", bus.err_resp_underflow, 0);
    tick();
    bus.req_valid = 3'b100;
    for (int d = 0; d < 4; d++) begin
      settle();
      chk("lim_ready", bus.req_ready, 4);
      tick();
    end
    settle();
    chk("lim_block", bus.req_ready, 0);
    chk("lim_cnt", bus.outst_cnt, 12'h400);
    chk("lim_src", bus.mst_src, 2);
    tick();
    bus.resp_fire = 1'b1;
    bus.resp_src = 2'd2;
    settle();
    chk("lim_no_unblock", bus.req_ready, 0);
    tick();
    bus.resp_fire = 1'b0;
    settle();
    chk("lim_cnt3", bus.outst_cnt, 12'h300);
    chk("lim_unblocked", bus.req_ready, 4);
    tick();
    settle();
    chk("lim_cnt4", bus.outst_cnt, 12'h400);
    chk("lim_reblock", bus.req_ready, 0);
    tick();
    bus.req_valid = '0;
    for (int d = 0; d < 4; d++) resp(2);
    bus.req_valid = 3'b001;
    for (int e = 0; e < 4; e++) tick();
    bus.req_valid = 3'b011;
    for (int f = 0; f < 4; f++) begin
      settle();
      chk("other_ready", bus.req_ready, 2);
      tick();
    end
    bus.mst_ready = 1'b0;
    bus.req_valid = 3'b110;
    for (int h = 0; h < 5; h++) begin
      settle();
      chk("stall_valid", bus.mst_valid, 1);
      chk("stall_src", bus.mst_src, 1);
      chk("stall_info", bus.mst_info, info(1));
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_cnt", bus.outst_cnt, 12'h004);
      tick();
    end
    bus.mst_ready = 1'b1;
    settle();
    chk("resume_ready", bus.req_ready, 4);
    tick();
    bus.req_valid = '0;
    settle();
    chk("resume_src", bus.mst_src, 2);
    chk("resume_info", bus.mst_info, info(2));
    chk("resume_cnt", bus.outst_cnt, 12'h104);
    tick();
    for (int d = 0; d < 4; d++) resp(0);
    resp(2);
    settle();
    chk("clean_err", bus.err_resp_underflow, 0);
    chk("clean_cnt", bus.outst_cnt, 0);
    tick();
    resp(0);
    settle();
    chk("uflow_err", bus.err_resp_underflow, 1);
    chk("uflow_cnt", bus.outst_cnt, 0);
    tick();
    bus.req_valid = 3'b001;
    for (int e = 0; e < 3; e++) tick();
    bus.req_valid = '0;
    settle();
    chk("pre_rst_cnt", bus.outst_cnt, 12'h003);
    chk("pre_rst_valid", bus.mst_valid, 1);
    chk("pre_rst_err", bus.err_resp_underflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mid_rst_valid", bus.mst_valid, 0);
    chk("mid_rst_cnt", bus.outst_cnt, 0);
    chk("mid_rst_idle", bus.idle, 1);
    chk("mid_rst_err", bus.err_resp_underflow, 0);
    tick();
    resp(1);
    settle();
    chk("untracked_err", bus.err_resp_underflow, 1);
    chk("untracked_cnt", bus.outst_cnt, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vp_cache_req_sched.md
Name: vp_cache_req_sched

Overview:
Credit-aware, weighted round-robin scheduler that shares the single CPU-NOC cache request channel among the vector-core requesters: ORV64 I/F (0), VSTORE (1) and VLOAD (2).
- Tracks outstanding responses per response-expecting requester and blocks any requester that is at its limit, so one source cannot fill the response buffer.
- Sits between the requester ports and the NOC request port, replacing the plain round-robin arbiter.
- Observes response handshakes to return credits.

Parameters:
N_REQ, 3, number of requesters; index = priority-ring position
WIDTH, 128, request info width in bits ($bits of the cache request struct)
MAX_OUTST, 4, max outstanding responses per tracked requester (1..15)
WEIGHT, 2, max consecutive grants to one requester before forced rotation (1..15)
RESP_MASK, 3'b101, bit i set = requester i receives responses and is credit-tracked

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request valid
req_info  in  N_REQ*WIDTH  per-requester request payload
req_ready  out  N_REQ  per-requester accept
mst_valid  out  1  request to NOC valid (registered)
mst_info  out  WIDTH  request payload (registered)
mst_src  out  $clog2(N_REQ)  index of granted requester (registered)
mst_ready  in  1  NOC accepts request
resp_fire  in  1  response handshake completed (valid&ready) at requester side
resp_src  in  $clog2(N_REQ)  requester index of that response
outst_cnt  out  N_REQ*4  current outstanding count per requester
idle  out  1  no request held and all outstanding counts zero
err_resp_underflow  out  1  sticky: response for requester with zero count or untracked requester

Behaviour:
- Reset (rst=1 at posedge): mst_valid=0, mst_info=0, mst_src=0, all outst_cnt=0, rr pointer=0, state=ARB, burst_cnt=0, err_resp_underflow=0. idle=1 after reset. Mid-operation reset discards the held request and all credits.
- Output stage: one-entry register. load_en = !mst_valid | mst_ready, i.e. full throughput, one beat per cycle.
- Eligibility: elig[i] = req_valid[i] & (!RESP_MASK[i] | outst_cnt[i] < MAX_OUTST).
- Grant: computed combinationally. req_ready[g]=load_en for the single granted g; all other req_ready=0. Never more than one req_ready high.
- Accept: when req_valid[g]&req_ready[g], the register loads req_info[g] and mst_src=g. Latency is 1 cycle (mst_valid rises the cycle after accept).
- State machine:
  - ARB: g = first eligible index searching from the rr pointer upward, with wrap.
    - On accept: if WEIGHT>1 go to BURST, owner=g, burst_cnt=1. Otherwise rr pointer=g+1 (mod N_REQ).
  - BURST: if elig[owner], g=owner. On accept, burst_cnt++. When burst_cnt reaches WEIGHT, rr pointer=owner+1 and go to ARB.
    - If !elig[owner] in BURST, there is no grant that cycle: rr pointer=owner+1, go to ARB (one-cycle bubble allowed).
  - If no requester is eligible in ARB: no grant; pointer unchanged.
- Credits, tracked i only:
  - inc when accepted into the output register;
  - dec on resp_fire with resp_src==i.
  - Simultaneous inc and dec on the same i leaves the count unchanged.
  - dec at 0, or resp_fire for an untracked src: count unchanged, err_resp_underflow set (cleared only by reset).
  - Count never exceeds MAX_OUTST because eligibility blocks at the limit.
  - Untracked outst_cnt is always 0.
- The credit check uses the pre-update count. A response arriving in the same cycle does not unblock that cycle.
- idle = !mst_valid & (all outst_cnt==0).
- mst_info/mst_src stay stable while mst_valid & !mst_ready.

Test Plan:
- Reset mid-burst: rst with mst_valid=1, outst_cnt[0]=3 -> next cycle mst_valid=0, all counts 0, idle=1, err=0.
- All three valid continuously, mst_ready=1, responses returned same cycle, WEIGHT=2 -> grant order 0,0,1,1,2,2,0,0…; one beat per cycle; mst_valid rises 1 cycle after first accept.
- Req 2 only, no responses, MAX_OUTST=4 -> 4 accepts, outst_cnt[2]=4, req_ready[2]=0. One resp_fire(src=2) -> count 3, accept the next cycle.
- Req 0 at limit (4), req 1 valid -> req 1 granted every cycle; outst_cnt[1] stays 0.
- Same-cycle accept for req 0 and resp_fire src=0 at count 2 -> count stays 2.
- resp_fire src=1, or src=0 at count 0 -> err_resp_underflow=1 stays high; counts unchanged.
- mst_ready=0 for 5 cycles with a held beat -> mst_info/mst_src stable; all req_ready=0; counts unchanged.
